// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
//
// Sequential ALU control decoder. A request (funct + ALUOp) is accepted
// with a valid/ready handshake. The decoded ALU operation code, result mux
// select and illegal flag are returned as a registered result with a second
// valid/ready handshake. Single-cycle operations are returned on the next
// cycle. When the optional multiply/divide support is built, MULT and DIV
// are returned after a programmable latency spent in a BUSY state.
//
// Optional feature macro: ALU_CTRL_MULDIV_EN
//   defined   -> MULT/DIV decode through BUSY with MUL_LAT / DIV_LAT latency
//   undefined -> MULT/DIV are illegal, BUSY is never entered, busy_o is 0
//
// Parameters
//   OP_W     width of ALU_operation_o (4-bit codes are zero-extended)
//   MUL_LAT  cycles from MULT accept to valid_o (2..15)
//   DIV_LAT  cycles from DIV accept to valid_o (2..15)
//
// Ports
//   clk_i            clock, all state on the rising edge
//   rst_i            synchronous active-high reset
//   valid_i          upstream request valid
//   ready_o          block can accept a request this cycle
//   funct_i[5:0]     R-type function field
//   ALUOp_i[2:0]     main-control ALU op class
//   valid_o          registered result valid
//   ready_i          downstream accepts the result
//   ALU_operation_o  ALU operation code
//   FURslt_o[1:0]    result mux select (00 ALU, 01 shifter, 10 LUI, 11 mul/div)
//   illegal_o        delivered request was not in the decode table
//   busy_o           high while a multiply/divide is in progress
// ---------------------------------------------------------------------------
module alu_ctrl_seq #(
  parameter int OP_W    = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [5:0]      funct_i,
  input  logic [2:0]      ALUOp_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [OP_W-1:0] ALU_operation_o,
  output logic [1:0]      FURslt_o,
  output logic            illegal_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    BUSY = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [1:0]      fur_q, fur_d;
  logic            ill_q, ill_d;

  logic            accept;
  logic [3:0]      dec_op;
  logic [1:0]      dec_fur;
  logic            dec_ill;

`ifdef ALU_CTRL_MULDIV_EN
  // The counter starts at LAT-1 so that BUSY lasts exactly LAT cycles.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_LAT - 1);

  logic       dec_long;
  logic       dec_div;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_div_q, pend_div_d;
`else
  // Latency parameters have no role without multiply/divide support.
  logic unused_lat;
  assign unused_lat = ^{4'(MUL_LAT), 4'(DIV_LAT)};
`endif

  // Handshake: ready is forced low during reset so nothing is accepted.
  assign ready_o = !rst_i && ((state_q == IDLE) || (state_q == OUT && ready_i));
  assign accept  = valid_i && ready_o;

  assign valid_o         = (state_q == OUT);
  assign ALU_operation_o = op_q;
  assign FURslt_o        = fur_q;
  assign illegal_o       = ill_q;
`ifdef ALU_CTRL_MULDIV_EN
  assign busy_o = (state_q == BUSY);
`else
  assign busy_o = 1'b0;
`endif

  // Decode table. Anything not listed is flagged illegal with op 0 / sel 00.
  always_comb begin
    dec_op  = 4'b0000;
    dec_fur = 2'b00;
    dec_ill = 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
    dec_long = 1'b0;
    dec_div  = 1'b0;
`endif
    case (ALUOp_i)
      3'b010: begin
        case (funct_i)
          6'b010011: dec_op = 4'b0010;
          6'b010001: dec_op = 4'b0110;
          6'b010100: dec_op = 4'b0000;
          6'b010110: dec_op = 4'b0001;
          6'b010101: dec_op = 4'b1100;
          6'b110000: dec_op = 4'b0111;
          6'b000000: begin dec_op = 4'b0011; dec_fur = 2'b01; end
          6'b000010: begin dec_op = 4'b0100; dec_fur = 2'b01; end
          6'b000110: dec_op = 4'b0101;
          6'b000100: dec_op = 4'b1000;
`ifdef ALU_CTRL_MULDIV_EN
          6'b011000: dec_long = 1'b1;
          6'b011010: begin dec_long = 1'b1; dec_div = 1'b1; end
`endif
          default:   dec_ill = 1'b1;
        endcase
      end
      3'b011, 3'b000: dec_op = 4'b0010;
      3'b001:         dec_op = 4'b0110;
      3'b100:         dec_fur = 2'b10;
      default:        dec_ill = 1'b1;
    endcase
  end

  // Next-state logic. Result registers only change when a new result is
  // delivered, so they hold their value through IDLE and BUSY.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fur_d   = fur_q;
    ill_d   = ill_q;
`ifdef ALU_CTRL_MULDIV_EN
    cnt_d      = cnt_q;
    pend_div_d = pend_div_q;
`endif
    case (state_q)
      IDLE, OUT: begin
        if (state_q == OUT && !ready_i) begin
          state_d = OUT;
        end else if (accept) begin
`ifdef ALU_CTRL_MULDIV_EN
          if (dec_long) begin
            state_d    = BUSY;
            cnt_d      = dec_div ? DIV_LOAD : MUL_LOAD;
            pend_div_d = dec_div;
          end else begin
            state_d = OUT;
            op_d    = OP_W'(dec_op);
            fur_d   = dec_fur;
            ill_d   = dec_ill;
          end
`else
          state_d = OUT;
          op_d    = OP_W'(dec_op);
          fur_d   = dec_fur;
          ill_d   = dec_ill;
`endif
        end else begin
          state_d = IDLE;
        end
      end
`ifdef ALU_CTRL_MULDIV_EN
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = OUT;
          op_d    = pend_div_q ? OP_W'(4'b1010) : OP_W'(4'b1001);
          fur_d   = 2'b11;
          ill_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      fur_q   <= 2'b00;
      ill_q   <= 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
      cnt_q      <= 4'd0;
      pend_div_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fur_q   <= fur_d;
      ill_q   <= ill_d;
`ifdef ALU_CTRL_MULDIV_EN
      cnt_q      <= cnt_d;
      pend_div_q <= pend_div_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_seq
//
// Self-checking bench for alu_ctrl_seq. A transaction-level reference model
// (lookup table for the decode, a "result held" flag and a remaining-wait
// count for multiply/divide) predicts ready_o and all outputs each cycle.
// Directed sequences are followed by randomized traffic.
// Honours ALU_CTRL_MULDIV_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_seq;

  localparam int OP_W    = 4;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [5:0]      funct_i = '0;
  logic [2:0]      ALUOp_i = '0;
  logic            valid_o;
  logic            ready_i = 1'b0;
  logic [OP_W-1:0] ALU_operation_o;
  logic [1:0]      FURslt_o;
  logic            illegal_o;
  logic            busy_o;

  int errors = 0;
  int checks = 0;

  // Reference decode table indexed by {ALUOp, funct}: {illegal, op[3:0], sel[1:0]}
  logic [6:0] refTable [512];
  bit         refLong  [512];
  bit         refDiv   [512];

  // Reference model state
  bit         modelKnown = 0;
  bit         resValid   = 0;
  logic [6:0] resEntry   = '0;
  int         waitLeft   = 0;
  logic [6:0] pendEntry  = '0;

  alu_ctrl_seq #(
    .OP_W    (OP_W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .funct_i         (funct_i),
    .ALUOp_i         (ALUOp_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .ALU_operation_o (ALU_operation_o),
    .FURslt_o        (FURslt_o),
    .illegal_o       (illegal_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic setEntry(input logic [2:0] aluop, input logic [5:0] f,
                          input logic [3:0] op, input logic [1:0] sel);
    refTable[{aluop, f}] = {1'b0, op, sel};
  endtask

  task automatic buildTable();
    for (int i = 0; i < 512; i++) begin
      refTable[i] = 7'b1_0000_00;
      refLong[i]  = 1'b0;
      refDiv[i]   = 1'b0;
    end
    for (int f = 0; f < 64; f++) begin
      setEntry(3'b011, 6'(f), 4'b0010, 2'b00);
      setEntry(3'b000, 6'(f), 4'b0010, 2'b00);
      setEntry(3'b001, 6'(f), 4'b0110, 2'b00);
      setEntry(3'b100, 6'(f), 4'b0000, 2'b10);
    end
    setEntry(3'b010, 6'b010011, 4'b0010, 2'b00);
    setEntry(3'b010, 6'b010001, 4'b0110, 2'b00);
    setEntry(3'b010, 6'b010100, 4'b0000, 2'b00);
    setEntry(3'b010, 6'b010110, 4'b0001, 2'b00);
    setEntry(3'b010, 6'b010101, 4'b1100, 2'b00);
    setEntry(3'b010, 6'b110000, 4'b0111, 2'b00);
    setEntry(3'b010, 6'b000000, 4'b0011, 2'b01);
    setEntry(3'b010, 6'b000010, 4'b0100, 2'b01);
    setEntry(3'b010, 6'b000110, 4'b0101, 2'b00);
    setEntry(3'b010, 6'b000100, 4'b1000, 2'b00);
`ifdef ALU_CTRL_MULDIV_EN
    setEntry(3'b010, 6'b011000, 4'b1001, 2'b11);
    setEntry(3'b010, 6'b011010, 4'b1010, 2'b11);
    refLong[{3'b010, 6'b011000}] = 1'b1;
    refLong[{3'b010, 6'b011010}] = 1'b1;
    refDiv[{3'b010, 6'b011010}]  = 1'b1;
`endif
  endtask

  // One clock cycle: check outputs left by the previous edge, drive new
  // inputs, check ready_o, then advance the model across the coming edge.
  task automatic applyStimulus(input bit r, input bit v, input logic [2:0] aluop,
                               input logic [5:0] f, input bit rdy);
    bit         expReady;
    bit         acc;
    int         idx;
    @(negedge clk_i);
    if (modelKnown) begin
      checkOutput("valid_o",   32'(valid_o),         32'(resValid));
      checkOutput("op",        32'(ALU_operation_o), 32'(resEntry[5:2]));
      checkOutput("FURslt",    32'(FURslt_o),        32'(resEntry[1:0]));
      checkOutput("illegal_o", 32'(illegal_o),       32'(resEntry[6]));
      checkOutput("busy_o",    32'(busy_o),          32'(waitLeft > 0));
    end
    rst_i   = r;
    valid_i = v;
    ALUOp_i = aluop;
    funct_i = f;
    ready_i = rdy;
    #1;
    expReady = !r && ((!resValid && waitLeft == 0) || (resValid && rdy));
    if (modelKnown) checkOutput("ready_o", 32'(ready_o), 32'(expReady));

    idx = int'({aluop, f});
    acc = v && expReady;
    if (r) begin
      resValid   = 0;
      resEntry   = '0;
      waitLeft   = 0;
      modelKnown = 1;
    end else if (waitLeft > 0) begin
      waitLeft--;
      if (waitLeft == 0) begin
        resValid = 1;
        resEntry = pendEntry;
      end
    end else if (resValid && !rdy) begin
      resValid = 1;
    end else if (acc) begin
      if (refLong[idx]) begin
        resValid  = 0;
        waitLeft  = refDiv[idx] ? DIV_LAT : MUL_LAT;
        pendEntry = refTable[idx];
      end else begin
        resValid = 1;
        resEntry = refTable[idx];
      end
    end else begin
      resValid = 0;
    end
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 3'b000, 6'b000000, rdy);
  endtask

  initial begin
    logic [5:0] functList [12];
    logic [2:0] aluop;
    logic [5:0] f;
    bit         r, v, rdy;

    functList = '{6'b010011, 6'b010001, 6'b010100, 6'b010110, 6'b010101, 6'b110000,
                  6'b000000, 6'b000010, 6'b000110, 6'b000100, 6'b011000, 6'b011010};
    buildTable();

    // Reset, then a single ADD
    applyStimulus(1, 0, 3'b000, 6'b000000, 1);
    applyStimulus(1, 1, 3'b010, 6'b010011, 1);
    applyStimulus(0, 1, 3'b010, 6'b010011, 1);
    idleCycles(2, 1);

    // Back-to-back SLL, SRL, ADDI, LUI
    applyStimulus(0, 1, 3'b010, 6'b000000, 1);
    applyStimulus(0, 1, 3'b010, 6'b000010, 1);
    applyStimulus(0, 1, 3'b011, 6'b101010, 1);
    applyStimulus(0, 1, 3'b100, 6'b111111, 1);
    idleCycles(2, 1);

    // Held result with a pending request, then release
    applyStimulus(0, 1, 3'b010, 6'b010001, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 3'b010, 6'b010101, 0);
    applyStimulus(0, 1, 3'b010, 6'b010101, 1);
    idleCycles(2, 1);

    // Illegal ALUOp and illegal funct
    applyStimulus(0, 1, 3'b111, 6'($urandom_range(0, 63)), 1);
    applyStimulus(0, 1, 3'b010, 6'b111111, 1);
    idleCycles(1, 1);

    // MULT, DIV, and MULT interrupted by reset
    applyStimulus(0, 1, 3'b010, 6'b011000, 1);
    idleCycles(MUL_LAT + 3, 1);
    applyStimulus(0, 1, 3'b010, 6'b011010, 1);
    for (int i = 0; i < DIV_LAT + 3; i++) applyStimulus(0, 1, 3'b010, 6'b010011, i > DIV_LAT);
    applyStimulus(0, 1, 3'b010, 6'b011000, 1);
    applyStimulus(0, 1, 3'b010, 6'b011000, 1);
    applyStimulus(1, 1, 3'b010, 6'b010011, 1);
    idleCycles(MUL_LAT + 2, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: aluop = 3'b010;
        3:       aluop = 3'b011;
        4:       aluop = 3'b000;
        5:       aluop = 3'b001;
        6:       aluop = 3'b100;
        default: aluop = 3'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 4) == 0) f = 6'($urandom_range(0, 63));
      else                          f = functList[$urandom_range(0, 11)];
      r   = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 7);
      applyStimulus(r, v, aluop, f, rdy);
    end
    idleCycles(DIV_LAT + 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter OP_W, default 4, width of ALU_operation_o.
REQ-002 SHALL have parameter MUL_LAT, default 4, MULT cycles from accept to valid_o (legal 2..15).
REQ-003 SHALL have parameter DIV_LAT, default 8, DIV cycles from accept to valid_o (legal 2..15).
REQ-004 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port valid_i  in  1  upstream decode request valid.
REQ-007 SHALL have port ready_o  out  1  block can accept a request this cycle.
REQ-008 SHALL have port funct_i  in  6  R-type function field.
REQ-009 SHALL have port ALUOp_i  in  3  main-control ALU op class.
REQ-010 SHALL have port valid_o  out  1  registered decode result valid.
REQ-011 SHALL have port ready_i  in  1  downstream accepts result.
REQ-012 SHALL have port ALU_operation_o  out  OP_W  ALU operation code.
REQ-013 SHALL have port FURslt_o  out  2  result mux select (00 ALU, 01 shifter, 10 LUI, 11 mul/div).
REQ-014 SHALL have port illegal_o  out  1  decoded request was not in the table.
REQ-015 SHALL have port busy_o  out  1  high while in BUSY state.

Function
REQ-016 Accept SHALL occur when valid_i && ready_o at a rising edge; funct_i/ALUOp_i sampled only then.
REQ-017 ready_o SHALL = (state==IDLE) || (state==OUT && ready_i); combinational, no dependence on valid_i.
REQ-018 Decode, ALUOp 010: funct 010011->0010/00, 010001->0110/00, 010100->0000/00, 010110->0001/00, 010101->1100/00, 110000->0111/00, 000000->0011/01, 000010->0100/01, 000110->0101/00, 000100->1000/00 (op/FURslt).
REQ-019 Decode: ALUOp 011 (ADDI) and 000 (load/store) ->0010/00; 001 (branch) ->0110/00; 100 (LUI) ->0000/10; funct ignored.
REQ-020 Any other ALUOp/funct combination SHALL be illegal: op 0000, FURslt 00, illegal_o 1, still delivered with valid_o and normal handshake.
REQ-021 Operation codes SHALL be zero-extended to OP_W when OP_W>4.
REQ-022 States: IDLE (valid_o 0), OUT (valid_o 1, outputs stable), BUSY (valid_o 0, counting).
REQ-023 IDLE: accept of single-cycle op -> OUT next cycle (latency 1); accept of MULT/DIV -> BUSY; no accept -> IDLE.
REQ-024 OUT: ready_i 0 -> stay, outputs unchanged; ready_i 1 and new accept -> reload (OUT or BUSY), back-to-back throughput 1/cycle; ready_i 1, no accept -> IDLE.
REQ-025 BUSY: 4-bit down-counter loaded with LAT-1 on accept, decremented each cycle; at 0 -> OUT with registered mul/div decode; valid_i ignored in BUSY.
REQ-026 Outputs in IDLE/BUSY SHALL hold last delivered values except valid_o.
REQ-027 Simultaneous ready_i drop and new valid_i in OUT SHALL not accept (ready_o 0); held result not overwritten.

Reset
REQ-028 rst_i high at a rising edge SHALL force IDLE, counter 0, valid_o 0, ALU_operation_o 0, FURslt_o 00, illegal_o 0, busy_o 0.
REQ-029 Reset SHALL take priority over any accept, including mid-BUSY; the pending mul/div is discarded, no valid_o follows.
REQ-030 ready_o SHALL be 0 while rst_i is high, 1 the cycle after release.

Configuration
REQ-031 Macro ALU_CTRL_MULDIV_EN defined: ALUOp 010 funct 011000 (MULT) ->1001/11 after MUL_LAT cycles, 011010 (DIV) ->1010/11 after DIV_LAT cycles via BUSY.
REQ-032 Macro undefined: MULT/DIV functs illegal per REQ-020, BUSY unreachable, busy_o tied 0, counter not built.

Verification
REQ-033 Reset then ALUOp 010 funct 010011 valid 1 cycle, ready_i 1 -> next cycle valid_o 1, op 0010, FURslt 00, then IDLE.
REQ-034 Stream SLL, SRL, ADDI, LUI back-to-back, ready_i 1 -> valid_o 4 consecutive cycles: 0011/01, 0100/01, 0010/00, 0000/10.
REQ-035 Result held, ready_i 0 for 3 cycles with valid_i 1 -> ready_o 0, outputs unchanged; ready_i 1 -> pending request accepted same edge.
REQ-036 ALUOp 111 any funct -> valid_o 1, illegal_o 1, op 0000, FURslt 00.
REQ-037 MULDIV_EN, MUL_LAT 4, MULT accepted at cycle 0 -> busy_o cycles 1-4, valid_o cycle 5 op 1001 FURslt 11; same with rst_i at cycle 2 -> no valid_o, IDLE cycle 3.
REQ-038 MULDIV_EN undefined, DIV funct -> valid_o next cycle, illegal_o 1, busy_o never 1.
